// File: rtl/cam_frame_if.sv
// Camera-side strobes and frame-buffer write bus for the capture sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface cam_frame_if #(
    parameter int ADDR_W = 19
);
    logic              i_start;
    logic              i_continuous;
    logic              i_vsync;
    logic              i_href;
    logic              i_pix_valid;
    logic [15:0]       i_pixel;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_frame_err;

    modport master (
        output i_start, i_continuous, i_vsync, i_href, i_pix_valid, i_pixel,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_err
    );

    modport slave (
        input  i_start, i_continuous, i_vsync, i_href, i_pix_valid, i_pixel,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_err
    );
endinterface

// File: rtl/cam_frame_ctrl.sv
// VSYNC-aligned frame capture sequencer: turns assembled RGB565 pixels into frame-buffer writes.
// Build option CAM_CAPTURE_DECIM_EN: 2x decimation (only even columns of even rows are written).
module cam_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic       i_pclk,
    input  logic       i_rst,
    cam_frame_if.slave bus
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_END = ROW_W'(V_ACTIVE);
`ifdef CAM_CAPTURE_DECIM_EN
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE / 2);
`else
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        CAPTURE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              href_q, vsync_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic              line_end;
    logic              frame_end;
    logic              pix_in;
    logic              in_range;
    logic              keep_pix;
    logic              keep_row;
    logic [ROW_W-1:0]  row_inc;
    logic [ROW_W-1:0]  row_chk;
    logic [ADDR_W-1:0] base_adv;

    assign line_end  = href_q & ~bus.i_href;
    assign frame_end = ~vsync_q & bus.i_vsync;
    assign pix_in    = bus.i_pix_valid & bus.i_href;
    assign in_range  = (col_q < COL_END) && (row_q < ROW_END);

`ifdef CAM_CAPTURE_DECIM_EN
    assign keep_pix = ~col_q[0] & ~row_q[0];
    assign keep_row = ~row_q[0];
`else
    assign keep_pix = 1'b1;
    assign keep_row = 1'b1;
`endif

    assign row_inc = (row_q == ROW_END) ? row_q : row_q + 1'b1;
    // A line closing on the same edge as VSYNC rises counts toward the frame check.
    assign row_chk = line_end ? row_inc : row_q;
    // Extra lines past the frame never write, so the base is frozen to avoid wrapping.
    assign base_adv = ((row_q < ROW_END) && keep_row) ? base_q + STRIDE : base_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        addr_d    = addr_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) state_d = ARM;
            end
            ARM: begin
                if (bus.i_vsync) state_d = SYNC;
            end
            SYNC: begin
                col_d  = '0;
                row_d  = '0;
                base_d = '0;
                addr_d = '0;
                err_d  = 1'b0;
                if (!bus.i_vsync) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (pix_in) begin
                    if (in_range) begin
                        col_d = col_q + 1'b1;
                        if (keep_pix) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = bus.i_pixel;
                            addr_d    = addr_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (line_end) begin
                    if (col_q != COL_END) err_d = 1'b1;
                    row_d  = row_inc;
                    col_d  = '0;
                    base_d = base_adv;
                    addr_d = base_adv;
                end
                if (frame_end) begin
                    if (row_chk != ROW_END) err_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // VSYNC is already high here, so continuous capture skips ARM.
                state_d = bus.i_continuous ? SYNC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            href_q    <= 1'b0;
            vsync_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            href_q    <= bus.i_href;
            vsync_q   <= bus.i_vsync;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_wr_data    = wr_data_q;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_frame_done = (state_q == DONE);
    assign bus.o_frame_err  = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed bench for cam_frame_ctrl on a 4x2 geometry: per-cycle vector table plus reset sequences.
module tb_cam_frame_ctrl;

    localparam int AW = 4;
`ifdef CAM_CAPTURE_DECIM_EN
    localparam int EXP_RST_WR = 2;
`else
    localparam int EXP_RST_WR = 5;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_frame_if #(.ADDR_W(AW)) bus ();

    cam_frame_ctrl #(
        .H_ACTIVE(4),
        .V_ACTIVE(2),
        .ADDR_W  (AW)
    ) dut (
        .i_pclk(clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          st, co, vs, hr, pv;
        logic [15:0]   px;
        logic          we;
        logic [AW-1:0] ad;
        logic [15:0]   dt;
        logic          bz, dn, er;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic st, co, vs, hr, pv, input logic [15:0] px,
                              input logic we, input int ad, input logic [15:0] dt,
                              input logic bz, dn, er);
        vec_t r;
        r.st = st; r.co = co; r.vs = vs; r.hr = hr; r.pv = pv; r.px = px;
        r.we = we; r.ad = AW'(ad); r.dt = dt; r.bz = bz; r.dn = dn; r.er = er;
        tbl.push_back(r);
    endfunction

    // start pulse in IDLE, VSYNC high (ARM->SYNC), VSYNC low (SYNC->CAPTURE)
    function automatic void arm(input logic co);
        v(1, co, 0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
        v(0, co, 1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
        v(0, co, 0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
    endfunction

    // n pixels d0, d0-1, ...; the first nwr are expected at a0, a0+1, ...; then HREF falls
    function automatic void line(input logic co, input int n, input int d0, input int a0, input int nwr);
        for (int k = 0; k < n; k++)
            v(0, co, 0, 1, 1, 16'(d0 - k), (k < nwr), a0 + k, 16'(d0 - k), 1, 0, 0);
        v(0, co, 0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
    endfunction

    // VSYNC rise -> DONE pulse, then DONE -> SYNC (continuous) or IDLE
    function automatic void fend(input logic co, input logic er);
        v(0, co, 1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 1, er);
        v(0, co, 1, 0, 0, 16'h0, 0, 0, 16'h0, co, 0, 0);
    endfunction

    function automatic void idle();
        v(0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, co, vs, hr, pv, input logic [15:0] px);
        @(negedge clk);
        bus.i_start      = st;
        bus.i_continuous = co;
        bus.i_vsync      = vs;
        bus.i_href       = hr;
        bus.i_pix_valid  = pv;
        bus.i_pixel      = px;
        @(posedge clk);
        #1;
        if (bus.o_wr_en)
            $display("wr addr=%0d data=0x%04h", bus.o_wr_addr, bus.o_wr_data);
    endtask

    initial begin
        int nwr;

`ifdef CAM_CAPTURE_DECIM_EN
        arm(0);
        v(0, 0, 0, 1, 1, 16'h000F, 1, 0, 16'h000F, 1, 0, 0);
        v(0, 0, 0, 1, 1, 16'h000E, 0, 0, 16'h0000, 1, 0, 0);
        v(0, 0, 0, 1, 1, 16'h000D, 1, 1, 16'h000D, 1, 0, 0);
        v(0, 0, 0, 1, 1, 16'h000C, 0, 0, 16'h0000, 1, 0, 0);
        v(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        line(0, 4, 'hB, 0, 0);
        fend(0, 0); idle();
`else
        // nominal single shot
        arm(0); line(0, 4, 'h0F, 0, 4); line(0, 4, 'h0B, 4, 4); fend(0, 0); idle();
        // arm while a line is active: nothing written until after VSYNC
        v(1, 0, 0, 1, 1, 16'h1111, 0, 0, 16'h0, 1, 0, 0);
        v(0, 0, 0, 1, 1, 16'h2222, 0, 0, 16'h0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0, 1, 0, 0);
        v(0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0, 1, 0, 0);
        line(0, 4, 'h2F, 0, 4); line(0, 4, 'h2B, 4, 4); fend(0, 0); idle();
        // short first line
        arm(0); line(0, 3, 'h3F, 0, 3); line(0, 4, 'h3B, 4, 4); fend(0, 1); idle();
        // overlong line
        arm(0); line(0, 5, 'h4F, 0, 4); line(0, 4, 'h4B, 4, 4); fend(0, 1); idle();
        // overlong frame
        arm(0); line(0, 4, 'h5F, 0, 4); line(0, 4, 'h5B, 4, 4); line(0, 4, 'h57, 0, 0);
        fend(0, 1); idle();
        // continuous: three frames, no start between them
        arm(1); line(1, 4, 'h6F, 0, 4); line(1, 4, 'h6B, 4, 4); fend(1, 0);
        v(0, 1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
        line(1, 4, 'h7F, 0, 4); line(1, 4, 'h7B, 4, 4); fend(1, 0);
        v(0, 1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
        line(1, 4, 'h8F, 0, 4); line(1, 4, 'h8B, 4, 4); fend(0, 0); idle();
`endif

        rst              = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_continuous = 1'b0;
        bus.i_vsync      = 1'b0;
        bus.i_href       = 1'b0;
        bus.i_pix_valid  = 1'b0;
        bus.i_pixel      = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",   -1, 32'(bus.o_wr_en), 0);
        chk("rst_wr_addr", -1, 32'(bus.o_wr_addr), 0);
        chk("rst_wr_data", -1, 32'(bus.o_wr_data), 0);
        chk("rst_busy",    -1, 32'(bus.o_busy), 0);
        chk("rst_done",    -1, 32'(bus.o_frame_done), 0);
        chk("rst_err",     -1, 32'(bus.o_frame_err), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].co, tbl[i].vs, tbl[i].hr, tbl[i].pv, tbl[i].px);
            chk("wr_en", i, 32'(bus.o_wr_en), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk("wr_addr", i, 32'(bus.o_wr_addr), 32'(tbl[i].ad));
                chk("wr_data", i, 32'(bus.o_wr_data), 32'(tbl[i].dt));
            end
            chk("busy", i, 32'(bus.o_busy), 32'(tbl[i].bz));
            chk("frame_done", i, 32'(bus.o_frame_done), 32'(tbl[i].dn));
            if (tbl[i].dn)
                chk("frame_err", i, 32'(bus.o_frame_err), 32'(tbl[i].er));
        end

        // reset in the middle of the second line
        nwr = 0;
        drive(1, 0, 0, 0, 0, 16'h0);
        drive(0, 0, 1, 0, 0, 16'h0);
        drive(0, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 1, 16'(16'h00A0 + k));
            nwr += int'(bus.o_wr_en);
        end
        drive(0, 0, 0, 0, 0, 16'h0);
        drive(0, 0, 0, 1, 1, 16'h00B0);
        nwr += int'(bus.o_wr_en);
        chk("writes_before_rst", 0, 32'(nwr), 32'(EXP_RST_WR));
        rst = 1'b1;
        drive(0, 0, 0, 1, 1, 16'h00B1);
        chk("midrst_busy",    0, 32'(bus.o_busy), 0);
        chk("midrst_wr_en",   0, 32'(bus.o_wr_en), 0);
        chk("midrst_wr_addr", 0, 32'(bus.o_wr_addr), 0);
        chk("midrst_done",    0, 32'(bus.o_frame_done), 0);
        rst = 1'b0;
        drive(0, 0, 1, 0, 0, 16'h0);
        chk("post_rst_busy", 1, 32'(bus.o_busy), 0);
        chk("post_rst_done", 1, 32'(bus.o_frame_done), 0);
        drive(0, 0, 1, 0, 0, 16'h0);
        chk("post_rst_wr_en", 2, 32'(bus.o_wr_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
